reg_dump_engine: RTL and testbench
==================================

Name: reg_dump_engine

Overview:
- Parametrised register-snapshot-to-BRAM engine for the CPU test platform.
- On a start edge it captures a flattened register-file bus in one cycle. It then streams the captured words into a BRAM port at BASE_ADDR + i*STRIDE.
- A verify mode reads the region back and counts mismatches against the captured snapshot.
- Sits between the CPU register file and an AXI-BRAM-controller-facing RAM port for host readout.

Parameters:
- NUM_REGS, 32: number of registers dumped (>=2).
- DATA_W, 32: register/RAM word width (multiple of 8).
- ADDR_W, 32: RAM byte-address width.
- BASE_ADDR, 0: byte address of register 0.
- STRIDE, 4: byte-address increment per register.

Ports:
- clk, in, 1: sole clock; all logic on posedge.
- rst_n, in, 1: reset. One clock; reset is asynchronous and active-low.
- start_i, in, 1: level request; rising edge starts an operation.
- mode_i, in, 1: 0 = dump (write), 1 = verify (read-back compare); sampled at start edge.
- regs_i, in, NUM_REGS*DATA_W: flattened register file; reg k at bits [k*DATA_W +: DATA_W].
- busy_o, out, 1: operation in progress.
- done_o, out, 1: one-cycle completion pulse.
- err_cnt_o, out, clog2(NUM_REGS+1): verify mismatch count.
- ram_clk, out, 1: equals clk.
- ram_rst, out, 1: constant 0 (active-high RAM reset).
- ram_en, out, 1: RAM enable.
- ram_we, out, DATA_W/8: byte write enables.
- ram_addr, out, ADDR_W: byte address.
- ram_wr_data, out, DATA_W: write data.
- ram_rd_data, in, DATA_W: RAM read data; 1-cycle latency after the enabled read cycle.

Behaviour:

Reset values:
- ram_en=0, ram_we=0, ram_addr=0, ram_wr_data=0, busy_o=0, done_o=0, err_cnt_o=0.
- Snapshot array cleared. FSM returns to IDLE.
- start_q=1, so a start held high through reset does not trigger.

Start detection:
- Start edge = start_i & ~start_q; start_q <= start_i every cycle.
- Edges are ignored unless state is IDLE. No queuing.

Registered outputs:
- All RAM-side outputs are registered.
- Assertion of rst_n mid-operation forces reset values immediately and aborts. No partial-done pulse is generated.

FSM states: IDLE, XFER, DRAIN, DONE.

IDLE:
- On start edge (edge E0): latch all of regs_i into the snapshot, latch mode, clear err_cnt_o, idx<=0, go to XFER.
- busy_o rises in the cycle after E0.

XFER:
- Lasts exactly NUM_REGS cycles (C1..CN). In cycle Ck: ram_en=1, ram_addr=BASE_ADDR+(k-1)*STRIDE.
- Address arithmetic is in ADDR_W bits and wraps modulo 2^ADDR_W.
- Dump mode: ram_we all ones, ram_wr_data=snapshot[k-1].
- Verify mode: ram_we=0 and ram_wr_data holds 0.
- After CN:
  - dump mode goes to DONE;
  - verify mode goes to DRAIN.

Verify compare pipeline:
- In cycle C(k+1), ram_rd_data is compared to snapshot[k-1] using a 1-deep delayed index/valid.
- On inequality, err_cnt_o increments. It saturates at NUM_REGS, which is unreachable but specified.

DRAIN:
- One cycle (C(N+1)) with ram_en=0. The final compare happens here.
- Then go to DONE.

DONE:
- One cycle: done_o=1, busy_o=1, ram_en=0, ram_we=0. Then go to IDLE; busy_o falls the next cycle.
- err_cnt_o holds until the next start edge.

Latency from E0:
- Dump: done_o in cycle C(N+1).
- Verify: done_o in cycle C(N+2).

Snapshot timing:
- Changes on regs_i after E0 do not affect the current operation.
- ram_en is low in every cycle outside XFER.

Test Plan:
1. Reset, regs k=k+1 (k=0..31), mode 0, start pulse -> ram_en high 32 consecutive cycles; addr 0,4,...,124; data 1..32; we=4'hF; done_o one pulse the cycle after addr 124; busy_o high 33 cycles.
2. Dump then verify against a BRAM model holding the written data -> 32 reads with we=0, done_o at C34, err_cnt_o=0.
3. Corrupt model words 3 and 31 before verify -> err_cnt_o=2. Then a new start clears it to 0 at E0.
4. Change regs_i and toggle start_i mid-dump -> written data equals the E0 snapshot; no second operation; done_o exactly once.
5. Drop rst_n during XFER at word 10 -> all outputs 0 asynchronously, no done_o. With start_i held high through reset release -> no operation until start_i falls and rises.
6. NUM_REGS=8, DATA_W=64, BASE_ADDR=32'hFFFF_FFF0, STRIDE=8 -> ram_we=8'hFF; addresses FFFF_FFF0, FFFF_FFF8, 0000_0000, ... wrap correctly; done_o after 8 writes.

Source files
------------

// File: rtl/reg_dump_engine.sv
// Register-file snapshot engine: captures regs_i on a start edge, then streams the snapshot to a
// RAM port (dump) or reads the region back and counts mismatches against it (verify).
module reg_dump_engine #(
   parameter int unsigned       NUM_REGS  = 32,
   parameter int unsigned       DATA_W    = 32,
   parameter int unsigned       ADDR_W    = 32,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
   parameter int unsigned       STRIDE    = 4
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           start_i,
   input  logic                           mode_i,
   input  logic [NUM_REGS*DATA_W-1:0]     regs_i,
   output logic                           busy_o,
   output logic                           done_o,
   output logic [$clog2(NUM_REGS+1)-1:0]  err_cnt_o,
   output logic                           ram_clk,
   output logic                           ram_rst,
   output logic                           ram_en,
   output logic [DATA_W/8-1:0]            ram_we,
   output logic [ADDR_W-1:0]              ram_addr,
   output logic [DATA_W-1:0]              ram_wr_data,
   input  logic [DATA_W-1:0]              ram_rd_data
);

   localparam int unsigned CntW = $clog2(NUM_REGS + 1);
   localparam int unsigned IdxW = $clog2(NUM_REGS);
   localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_REGS - 1);
   localparam logic [CntW-1:0] CntMax  = CntW'(NUM_REGS);

   typedef enum logic [1:0] {StIdle, StXfer, StDrain, StDone} state_e;

   state_e              state_q;
   logic                start_q;
   logic                mode_q;
   logic [IdxW-1:0]     idx_q;
   logic                rd_vld_q;
   logic [IdxW-1:0]     rd_idx_q;
   logic [DATA_W-1:0]   snap_q [NUM_REGS];

   logic start_edge;
   logic rd_mismatch;

   assign ram_clk = clk;
   assign ram_rst = 1'b0;

   assign start_edge  = start_i & ~start_q;
   // Read data returns one cycle after the enabled read, so compare against the delayed index.
   assign rd_mismatch = rd_vld_q && (ram_rd_data != snap_q[rd_idx_q]);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         start_q     <= 1'b1;
         mode_q      <= 1'b0;
         idx_q       <= '0;
         rd_vld_q    <= 1'b0;
         rd_idx_q    <= '0;
         busy_o      <= 1'b0;
         done_o      <= 1'b0;
         err_cnt_o   <= '0;
         ram_en      <= 1'b0;
         ram_we      <= '0;
         ram_addr    <= '0;
         ram_wr_data <= '0;
         for (int unsigned k = 0; k < NUM_REGS; k++) begin
            snap_q[k] <= '0;
         end
      end else begin
         start_q  <= start_i;
         rd_vld_q <= 1'b0;
         if (rd_mismatch && (err_cnt_o != CntMax)) begin
            err_cnt_o <= err_cnt_o + CntW'(1);
         end

         unique case (state_q)
            StIdle: begin
               if (start_edge) begin
                  for (int unsigned k = 0; k < NUM_REGS; k++) begin
                     snap_q[k] <= regs_i[k*DATA_W +: DATA_W];
                  end
                  mode_q      <= mode_i;
                  err_cnt_o   <= '0;
                  idx_q       <= '0;
                  busy_o      <= 1'b1;
                  ram_en      <= 1'b1;
                  ram_addr    <= BASE_ADDR;
                  // The snapshot is not yet visible, so word 0 comes straight from the bus.
                  ram_we      <= mode_i ? '0 : '1;
                  ram_wr_data <= mode_i ? '0 : regs_i[DATA_W-1:0];
                  state_q     <= StXfer;
               end
            end

            StXfer: begin
               rd_vld_q <= mode_q;
               rd_idx_q <= idx_q;
               if (idx_q == LastIdx) begin
                  ram_en      <= 1'b0;
                  ram_we      <= '0;
                  ram_wr_data <= '0;
                  if (mode_q) begin
                     state_q <= StDrain;
                  end else begin
                     done_o  <= 1'b1;
                     state_q <= StDone;
                  end
               end else begin
                  idx_q    <= idx_q + IdxW'(1);
                  ram_addr <= ram_addr + ADDR_W'(STRIDE);
                  if (!mode_q) begin
                     ram_wr_data <= snap_q[idx_q + IdxW'(1)];
                  end
               end
            end

            StDrain: begin
               done_o  <= 1'b1;
               state_q <= StDone;
            end

            StDone: begin
               done_o  <= 1'b0;
               busy_o  <= 1'b0;
               state_q <= StIdle;
            end

            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_reg_dump_engine.sv
// Randomized bench for reg_dump_engine: two instances (default and wide/wrapping) checked against
// a cycle-timeline model and a word-array RAM model.
module tb_reg_dump_engine;

   localparam int unsigned NA       = 32;
   localparam int unsigned NB       = 8;
   localparam logic [31:0] BASE_B   = 32'hFFFF_FFF0;
   localparam int unsigned STRIDE_B = 8;

   logic clk = 1'b0;
   logic rst_n;

   logic              start_a, mode_a, busy_a, done_a, ram_clk_a, ram_rst_a, ram_en_a;
   logic [NA*32-1:0]  regs_a_flat;
   logic [5:0]        err_cnt_a;
   logic [3:0]        ram_we_a;
   logic [31:0]       ram_addr_a, ram_wr_data_a, rd_data_a;
   logic [31:0]       regs_a [NA];
   logic [31:0]       mem_a  [NA];

   logic              start_b, mode_b, busy_b, done_b, ram_clk_b, ram_rst_b, ram_en_b;
   logic [NB*64-1:0]  regs_b_flat;
   logic [3:0]        err_cnt_b;
   logic [7:0]        ram_we_b;
   logic [31:0]       ram_addr_b;
   logic [63:0]       ram_wr_data_b, rd_data_b;
   logic [63:0]       regs_b [NB];

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   always_comb begin
      regs_a_flat = '0;
      for (int k = 0; k < NA; k++) regs_a_flat[k*32 +: 32] = regs_a[k];
   end

   always_comb begin
      regs_b_flat = '0;
      for (int k = 0; k < NB; k++) regs_b_flat[k*64 +: 64] = regs_b[k];
   end

   // Word-addressed BRAM model for instance A (base 0, stride 4), read-first, 1-cycle latency.
   always @(posedge clk) begin
      if (ram_en_a) begin
         if (ram_we_a == 4'hF) mem_a[ram_addr_a[6:2]] <= ram_wr_data_a;
         rd_data_a <= mem_a[ram_addr_a[6:2]];
      end
   end

   reg_dump_engine #(
      .NUM_REGS(NA), .DATA_W(32), .ADDR_W(32), .BASE_ADDR(32'h0), .STRIDE(4)
   ) u_dut_a (
      .clk(clk), .rst_n(rst_n), .start_i(start_a), .mode_i(mode_a), .regs_i(regs_a_flat),
      .busy_o(busy_a), .done_o(done_a), .err_cnt_o(err_cnt_a), .ram_clk(ram_clk_a),
      .ram_rst(ram_rst_a), .ram_en(ram_en_a), .ram_we(ram_we_a), .ram_addr(ram_addr_a),
      .ram_wr_data(ram_wr_data_a), .ram_rd_data(rd_data_a)
   );

   reg_dump_engine #(
      .NUM_REGS(NB), .DATA_W(64), .ADDR_W(32), .BASE_ADDR(BASE_B), .STRIDE(STRIDE_B)
   ) u_dut_b (
      .clk(clk), .rst_n(rst_n), .start_i(start_b), .mode_i(mode_b), .regs_i(regs_b_flat),
      .busy_o(busy_b), .done_o(done_b), .err_cnt_o(err_cnt_b), .ram_clk(ram_clk_b),
      .ram_rst(ram_rst_b), .ram_en(ram_en_b), .ram_we(ram_we_b), .ram_addr(ram_addr_b),
      .ram_wr_data(ram_wr_data_b), .ram_rd_data(rd_data_b)
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_idle_a(input string tag);
      check_eq({tag, "_en"},    ram_en_a, 0);
      check_eq({tag, "_we"},    ram_we_a, 0);
      check_eq({tag, "_addr"},  ram_addr_a, 0);
      check_eq({tag, "_wdata"}, ram_wr_data_a, 0);
      check_eq({tag, "_busy"},  busy_a, 0);
      check_eq({tag, "_done"},  done_a, 0);
      check_eq({tag, "_err"},   err_cnt_a, 0);
      check_eq({tag, "_rst"},   ram_rst_a, 0);
   endtask

   task automatic randomize_regs_a();
      for (int k = 0; k < NA; k++) regs_a[k] = $urandom;
   endtask

   // Drives one operation on instance A from a negedge and checks every cycle of its timeline.
   task automatic run_a(input bit mode, input bit perturb, input int abort_at);
      logic [31:0] snap [NA];
      int total;
      int exp_err;
      snap    = regs_a;
      exp_err = 0;
      if (mode) for (int k = 0; k < NA; k++) if (mem_a[k] != snap[k]) exp_err++;
      total   = mode ? NA + 2 : NA + 1;
      mode_a  = mode;
      start_a = 1'b1;
      for (int j = 1; j <= total + 1; j++) begin
         @(negedge clk);
         if (j == abort_at) begin
            start_a = 1'b1;
            #2 rst_n = 1'b0;
            #1 check_idle_a("abort");
            return;
         end
         if (j <= total) begin
            check_eq("busy", busy_a, 1);
            check_eq("done", done_a, j == total);
            check_eq("en", ram_en_a, j <= NA);
            check_eq("we", ram_we_a, (j <= NA && !mode) ? 4'hF : 4'h0);
            if (j <= NA) begin
               check_eq("addr", ram_addr_a, 32'((j - 1) * 4));
               check_eq("wdata", ram_wr_data_a, mode ? 32'h0 : snap[j-1]);
            end
            if (j == 1) check_eq("err_clear", err_cnt_a, 0);
            if (j == total) check_eq("err_cnt", err_cnt_a, exp_err);
         end else begin
            check_eq("busy_end", busy_a, 0);
            check_eq("done_end", done_a, 0);
            check_eq("en_end", ram_en_a, 0);
            check_eq("err_hold", err_cnt_a, exp_err);
         end
         if (j == 2) mode_a = ~mode;
         if (!perturb && j == 1) start_a = 1'b0;
         if (perturb) begin
            if (j == 3) randomize_regs_a();
            if (j == 5) start_a = 1'b0;
            if (j == 7) start_a = 1'b1;
            if (j == 9) start_a = 1'b0;
         end
      end
   endtask

   task automatic run_b();
      logic [63:0] snap [NB];
      snap    = regs_b;
      start_b = 1'b1;
      for (int j = 1; j <= NB + 2; j++) begin
         @(negedge clk);
         if (j <= NB + 1) begin
            check_eq("b_busy", busy_b, 1);
            check_eq("b_done", done_b, j == NB + 1);
            check_eq("b_en", ram_en_b, j <= NB);
            check_eq("b_we", ram_we_b, (j <= NB) ? 8'hFF : 8'h00);
            if (j <= NB) begin
               check_eq("b_addr", ram_addr_b, 32'(BASE_B + 32'((j - 1) * STRIDE_B)));
               check_eq("b_wdata", ram_wr_data_b, snap[j-1]);
            end
         end else begin
            check_eq("b_busy_end", busy_b, 0);
            check_eq("b_done_end", done_b, 0);
         end
         if (j == 1) start_b = 1'b0;
      end
   endtask

   task automatic quiet_a(input int cycles, input string tag);
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         check_eq({tag, "_en"}, ram_en_a, 0);
         check_eq({tag, "_busy"}, busy_a, 0);
         check_eq({tag, "_done"}, done_a, 0);
      end
   endtask

   initial begin
      rst_n   = 1'b0;
      start_a = 1'b1;
      start_b = 1'b0;
      mode_a  = 1'b0;
      mode_b  = 1'b0;
      rd_data_b = '0;
      for (int k = 0; k < NA; k++) begin
         regs_a[k] = 32'(k + 1);
         mem_a[k]  = '0;
      end
      for (int k = 0; k < NB; k++) regs_b[k] = {$urandom, $urandom};
      #1 check_idle_a("reset");
      check_eq("reset_b_en", ram_en_b, 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      // Start held high through reset release must not trigger.
      quiet_a(4, "start_held");
      start_a = 1'b0;
      @(negedge clk);

      run_a(1'b0, 1'b0, 0);
      run_a(1'b1, 1'b0, 0);
      mem_a[3]  = mem_a[3] ^ 32'h0000_0100;
      mem_a[31] = mem_a[31] ^ 32'h8000_0001;
      run_a(1'b1, 1'b0, 0);
      check_eq("err_two", err_cnt_a, 2);
      randomize_regs_a();
      run_a(1'b0, 1'b0, 0);

      for (int it = 0; it < 3; it++) begin
         randomize_regs_a();
         run_a(1'b0, it == 0, 0);
         quiet_a(4, "no_second_op");
         for (int c = 0; c < int'($urandom_range(0, 3)); c++) begin
            int w;
            w = int'($urandom_range(0, NA - 1));
            mem_a[w] = mem_a[w] ^ (32'h1 << $urandom_range(0, 31));
         end
         run_a(1'b1, 1'b0, 0);
      end

      randomize_regs_a();
      run_a(1'b0, 1'b0, 11);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_eq("in_reset_done", done_a, 0);
         check_eq("in_reset_en", ram_en_a, 0);
      end
      rst_n = 1'b1;
      quiet_a(5, "post_abort");
      start_a = 1'b0;
      @(negedge clk);
      run_a(1'b0, 1'b0, 0);
      run_a(1'b1, 1'b0, 0);

      for (int k = 0; k < NB; k++) regs_b[k] = {$urandom, $urandom};
      run_b();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
